// File: rtl/sdma_sched_pkg.sv
// Shared types and helpers for the SDMA instruction scheduler.
package sdma_sched_pkg;

  localparam int unsigned SDMA_INSTWIDTH = 32;
  localparam int unsigned DEF_QDEPTH     = 4;

  typedef enum logic [1:0] {
    CH_IDLE = 2'b00,
    CH_CFG  = 2'b01,
    CH_WORK = 2'b10,
    CH_ILL  = 2'b11
  } ch_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  localparam int unsigned QCNT_W = clog2(DEF_QDEPTH + 1);

endpackage

// File: rtl/sdma_inst_fifo.sv
// Instruction queue: power-of-two depth, registered count, combinational head.
module sdma_inst_fifo
  import sdma_sched_pkg::*;
#(
  parameter int unsigned INST_W = SDMA_INSTWIDTH,
  parameter int unsigned QDEPTH = DEF_QDEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_push,
  input  logic                            i_pop,
  input  logic [INST_W-1:0]               i_data,
  output logic [INST_W-1:0]               o_head,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [clog2(QDEPTH+1)-1:0]      o_count
);

  localparam int unsigned PTR_W = clog2(QDEPTH);
  localparam int unsigned CNT_W = clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  logic [INST_W-1:0] r_mem [QDEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sdma_inst_sched.sv
// Queues SDMA instructions and dispatches them round-robin to NUM_CH
// independent IDLE/CFG/WORK transfer-control channels.
module sdma_inst_sched
  import sdma_sched_pkg::*;
#(
  parameter int unsigned INST_W = SDMA_INSTWIDTH,
  parameter int unsigned QDEPTH = DEF_QDEPTH,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  input  logic                         i_inst_vld,
  input  logic [INST_W-1:0]            i_inst,
  output logic                         o_inst_rdy,
  input  logic [NUM_CH-1:0]            i_ch_ready,
  input  logic [NUM_CH-1:0]            i_ch_done,
  output logic [NUM_CH-1:0]            o_ch_en,
  output logic [NUM_CH*INST_W-1:0]     o_ch_inst,
  output logic [clog2(QDEPTH+1)-1:0]   o_q_cnt,
  output logic                         o_idle,
  output logic                         o_err_done
);

  localparam int unsigned CNT_W = clog2(QDEPTH + 1);
  localparam int unsigned PTR_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic [INST_W-1:0]   w_head;
  logic [CNT_W-1:0]    w_cnt;
  logic                w_q_empty_nxt;

  logic [NUM_CH-1:0]   w_is_idle;
  logic [NUM_CH-1:0]   w_not_work;
  logic [NUM_CH-1:0]   w_idle_nxt;
  logic [NUM_CH-1:0]   w_elig;
  logic [2*NUM_CH-1:0] w_elig_dbl;
  logic [NUM_CH-1:0]   w_elig_rot;
  logic [NUM_CH-1:0]   w_grant;
  logic                w_gnt_any;
  logic [PTR_W-1:0]    w_win;
  logic [PTR_W-1:0]    w_rr_nxt;

  logic [PTR_W-1:0]    r_rr;
  logic                r_idle;
  logic                r_err_done;

  assign w_push     = i_inst_vld & ~w_full;
  assign o_inst_rdy = ~w_full;
  assign o_q_cnt    = w_cnt;
  assign o_idle     = r_idle;
  assign o_err_done = r_err_done;

  sdma_inst_fifo #(
    .INST_W (INST_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_gnt_any),
    .i_data  (i_inst),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  // Rotate eligibility so rr_ptr lands on bit 0, then take the lowest set bit.
  assign w_elig     = w_is_idle & i_ch_ready & {NUM_CH{i_en & ~w_empty}};
  assign w_elig_dbl = {w_elig, w_elig};
  assign w_elig_rot = NUM_CH'(w_elig_dbl >> r_rr);

  always_comb begin
    w_gnt_any = 1'b0;
    w_win     = '0;
    w_rr_nxt  = '0;
    w_grant   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!w_gnt_any && w_elig_rot[i]) begin
        w_gnt_any = 1'b1;
        w_win     = PTR_W'((32'(r_rr) + i) % NUM_CH);
        w_rr_nxt  = PTR_W'((32'(r_rr) + i + 1) % NUM_CH);
      end
    end
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_grant[k] = w_gnt_any && (w_win == PTR_W'(k));
    end
  end

  assign w_q_empty_nxt = ((w_cnt == '0) && !w_push) ||
                         ((w_cnt == CNT_W'(1)) && w_gnt_any && !w_push);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr       <= '0;
      r_idle     <= 1'b1;
      r_err_done <= 1'b0;
    end else begin
      if (w_gnt_any) r_rr <= w_rr_nxt;
      r_idle     <= w_q_empty_nxt & (&w_idle_nxt);
      r_err_done <= |(i_ch_done & w_not_work);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ch_state_e         r_state;
    logic              r_en;
    logic [INST_W-1:0] r_inst;

    assign w_is_idle[k]  = (r_state == CH_IDLE);
    assign w_not_work[k] = (r_state != CH_WORK);
    assign w_idle_nxt[k] = ((r_state == CH_IDLE) && !w_grant[k]) ||
                           ((r_state == CH_WORK) && i_ch_done[k]) ||
                           (r_state == CH_ILL);
    assign o_ch_en[k]                   = r_en;
    assign o_ch_inst[k*INST_W +: INST_W] = r_inst;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= CH_IDLE;
        r_en    <= 1'b0;
        r_inst  <= '0;
      end else begin
        case (r_state)
          CH_IDLE: if (w_grant[k]) begin
            r_state <= CH_CFG;
            r_en    <= 1'b1;
            r_inst  <= w_head;
          end
          CH_CFG: r_state <= CH_WORK;
          CH_WORK: if (i_ch_done[k]) begin
            r_state <= CH_IDLE;
            r_en    <= 1'b0;
            r_inst  <= '0;
          end
          default: begin
            r_state <= CH_IDLE;
            r_en    <= 1'b0;
            r_inst  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdma_inst_sched.sv
// Scoreboard bench for sdma_inst_sched: expected grants are queued at push time
// and matched against each rising channel enable by an independent monitor.
module tb_sdma_inst_sched;

  localparam int unsigned IW = 32;
  localparam int unsigned QD = 4;
  localparam int unsigned NC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              inst_vld;
  logic [IW-1:0]     inst;
  logic              inst_rdy;
  logic [NC-1:0]     ch_ready;
  logic [NC-1:0]     ch_done;
  logic [NC-1:0]     ch_en;
  logic [NC*IW-1:0]  ch_inst;
  logic [2:0]        q_cnt;
  logic              idle;
  logic              err_done;

  always #5 clk = ~clk;

  sdma_inst_sched #(
    .INST_W (IW),
    .QDEPTH (QD),
    .NUM_CH (NC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (en),
    .i_inst_vld (inst_vld),
    .i_inst     (inst),
    .o_inst_rdy (inst_rdy),
    .i_ch_ready (ch_ready),
    .i_ch_done  (ch_done),
    .o_ch_en    (ch_en),
    .o_ch_inst  (ch_inst),
    .o_q_cnt    (q_cnt),
    .o_idle     (idle),
    .o_err_done (err_done)
  );

  typedef struct packed {
    logic [7:0]    ch;
    logic [IW-1:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [NC-1:0] prev_en = '0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endfunction

  // Monitor: every new channel enable must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (ch_en[k] && !prev_en[k]) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL grant_unexpected: got ch%0d inst %h required no grant", k, ch_inst[k*IW +: IW]);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant", 64'({8'(k), ch_inst[k*IW +: IW]}), 64'({mon_e.ch, mon_e.inst}));
        end
      end
    end
    prev_en = ch_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    inst_vld = 1'b0;
    ch_done  = '0;
    step();
    rst = 1'b0;
  endtask

  function automatic exp_t mk(input int ch, input logic [IW-1:0] v);
    exp_t e;
    e.ch   = 8'(ch);
    e.inst = v;
    return e;
  endfunction

  logic [IW-1:0] vec [5];

  initial begin
    vec[0] = 32'hA0A0_0001; vec[1] = 32'hB0B0_0002; vec[2] = 32'hC0C0_0003;
    vec[3] = 32'hD0D0_0004; vec[4] = 32'hE0E0_0005;
    en = 1'b1; inst = '0; ch_ready = '0;
    rst = 1'b1; inst_vld = 1'b0; ch_done = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_en",   64'(ch_en),    64'(0));
    chk("rst_inst", 64'(ch_inst),  64'(0));
    chk("rst_cnt",  64'(q_cnt),    64'(0));
    chk("rst_err",  64'(err_done), 64'(0));
    chk("rst_idle", 64'(idle),     64'(1));
    chk("rst_rdy",  64'(inst_rdy), 64'(1));

    // Single instruction: enable rises two edges after push is presented
    ch_ready = 2'b11;
    inst = 32'h1111_AAAA; inst_vld = 1'b1;
    exp_q.push_back(mk(0, 32'h1111_AAAA));
    step();
    inst_vld = 1'b0;
    chk("t1_cnt1", 64'(q_cnt), 64'(1));
    chk("t1_en0",  64'(ch_en), 64'(0));
    step();
    chk("t1_en1",  64'(ch_en), 64'(2'b01));
    chk("t1_cnt0", 64'(q_cnt), 64'(0));
    chk("t1_busy", 64'(idle),  64'(0));
    step();
    ch_done = 2'b01;
    step();
    ch_done = '0;
    chk("t1_done_en",   64'(ch_en),   64'(0));
    chk("t1_done_inst", 64'(ch_inst), 64'(0));
    chk("t1_done_idle", 64'(idle),    64'(1));

    // Fill with channels not ready; fifth push refused
    do_reset();
    ch_ready = '0;
    for (int i = 0; i < 5; i++) begin
      inst = vec[i]; inst_vld = 1'b1;
      chk("t2_rdy", 64'(inst_rdy), 64'(i < 4));
      if (i < 4) exp_q.push_back(mk(i % 2, vec[i]));
      step();
    end
    inst_vld = 1'b0;
    chk("t2_full_cnt", 64'(q_cnt),    64'(4));
    chk("t2_full_rdy", 64'(inst_rdy), 64'(0));
    ch_ready = 2'b11;
    step();
    chk("t2_g1_cnt", 64'(q_cnt), 64'(3));
    step();
    chk("t2_g2_en",  64'(ch_en), 64'(2'b11));
    chk("t2_g2_cnt", 64'(q_cnt), 64'(2));
    step();
    ch_done = 2'b11;
    step();
    ch_done = '0;
    chk("t2_both_done_en", 64'(ch_en),    64'(0));
    chk("t2_both_done_err", 64'(err_done), 64'(0));
    step(); step();
    chk("t2_drain_cnt", 64'(q_cnt), 64'(0));
    chk("t2_drain_en",  64'(ch_en), 64'(2'b11));

    // Round-robin: pointer sits at 1 after ch0 was served
    do_reset();
    ch_ready = 2'b11;
    inst = 32'h3333_0000; inst_vld = 1'b1;
    exp_q.push_back(mk(0, 32'h3333_0000));
    step();
    inst_vld = 1'b0;
    step(); step();
    ch_done = 2'b01;
    step();
    ch_done = '0;
    inst = 32'h3333_0001; inst_vld = 1'b1;
    exp_q.push_back(mk(1, 32'h3333_0001));
    step();
    inst = 32'h3333_0002;
    exp_q.push_back(mk(0, 32'h3333_0002));
    step();
    inst_vld = 1'b0;
    chk("t3_first_ch1", 64'(ch_en), 64'(2'b10));
    step();
    chk("t3_rr_en", 64'(ch_en), 64'(2'b11));

    // Full queue: grant and push in same cycle, push refused
    do_reset();
    ch_ready = '0;
    for (int i = 0; i < 4; i++) begin
      inst = vec[i]; inst_vld = 1'b1;
      if (i == 0) exp_q.push_back(mk(0, vec[0]));
      step();
    end
    inst = vec[4]; ch_ready = 2'b01;
    chk("t4_full_rdy", 64'(inst_rdy), 64'(0));
    step();
    inst_vld = 1'b0; ch_ready = '0;
    chk("t4_pop_cnt", 64'(q_cnt), 64'(3));

    // Empty queue: push and grant attempt together, no grant that cycle
    do_reset();
    ch_ready = 2'b11;
    inst = 32'h4444_0001; inst_vld = 1'b1;
    exp_q.push_back(mk(0, 32'h4444_0001));
    step();
    inst_vld = 1'b0;
    chk("t4_nofall_en",  64'(ch_en), 64'(0));
    chk("t4_nofall_cnt", 64'(q_cnt), 64'(1));
    step();
    chk("t4_gnt_en", 64'(ch_en), 64'(2'b01));

    // Done on IDLE ch1 pulses err_done and changes nothing
    ch_done = 2'b10;
    step();
    ch_done = '0;
    chk("t5_err_pulse", 64'(err_done), 64'(1));
    chk("t5_err_en",    64'(ch_en),    64'(2'b01));
    step();
    chk("t5_err_clear", 64'(err_done), 64'(0));
    chk("t5_err_en2",   64'(ch_en),    64'(2'b01));

    // Reset mid-transfer with queued work; done during reset is dropped
    do_reset();
    ch_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      inst = vec[i]; inst_vld = 1'b1;
      if (i == 0) exp_q.push_back(mk(0, vec[0]));
      step();
    end
    inst_vld = 1'b0;
    chk("t6_pre_cnt", 64'(q_cnt), 64'(3));
    chk("t6_pre_en",  64'(ch_en), 64'(2'b01));
    rst = 1'b1; ch_done = 2'b01;
    step();
    chk("t6_rst_en",   64'(ch_en),    64'(0));
    chk("t6_rst_cnt",  64'(q_cnt),    64'(0));
    chk("t6_rst_idle", 64'(idle),     64'(1));
    chk("t6_rst_rdy",  64'(inst_rdy), 64'(1));
    chk("t6_rst_inst", 64'(ch_inst),  64'(0));
    rst = 1'b0; ch_done = '0;
    step();
    chk("t6_post_en",  64'(ch_en),    64'(0));
    chk("t6_post_err", 64'(err_done), 64'(0));
    step();

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
